// File: rtl/prime_pkg.sv
// prime_pkg -- shared definitions for the prime sweep controller.
//   sweep_state_e : sweep FSM states
//   *_W_DEF       : default widths for candidate/limit, prime count, cycle count
package prime_pkg;
  localparam int NUM_W_DEF = 10;
  localparam int CNT_W_DEF = 8;
  localparam int CYC_W_DEF = 20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_NEXT = 2'd2,
    ST_DONE = 2'd3
  } sweep_state_e;
endpackage

// File: rtl/sat_counter.sv
// sat_counter -- up-counter that sticks at all-ones.
//   SysClk : clock (rising edge)
//   Reset  : synchronous active-low reset, clears count
//   clr    : synchronous clear (wins over en)
//   en     : count enable
//   count  : current value
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             SysClk,
  input  logic             Reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge SysClk) begin
    if (!Reset)                    count <= '0;
    else if (clr)                  count <= '0;
    else if (en && (count != '1))  count <= count + WIDTH'(1);
  end
endmodule

// File: rtl/prime_sweep_ctrl.sv
// prime_sweep_ctrl -- walks candidates 2..NumMax through an external
// prime-test engine and tallies the verdicts.
//   SysClk, Reset          : clock, synchronous active-low reset
//   Start, Abort, NumMax   : sweep control; NumMax is the inclusive limit
//   EngReq/EngNum          : candidate handshake toward the engine
//   EngAck/EngPrime        : engine result and verdict
//   Prime                  : one-cycle pulse after a prime verdict is taken
//   NumberChecked          : last candidate whose result was taken
//   NumberofPrimesFound    : saturating prime tally for this sweep
//   ClockCount             : saturating busy-cycle tally for this sweep
//   Busy, Done             : status levels
module prime_sweep_ctrl
  import prime_pkg::*;
#(
  parameter int NUM_W = NUM_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int CYC_W = CYC_W_DEF
) (
  input  logic             SysClk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Abort,
  input  logic [NUM_W-1:0] NumMax,
  output logic             EngReq,
  output logic [NUM_W-1:0] EngNum,
  input  logic             EngAck,
  input  logic             EngPrime,
  output logic             Prime,
  output logic [NUM_W-1:0] NumberChecked,
  output logic [CNT_W-1:0] NumberofPrimesFound,
  output logic [CYC_W-1:0] ClockCount,
  output logic             Busy,
  output logic             Done
);
  sweep_state_e     state_q, state_d;
  logic [NUM_W-1:0] max_q, cand_q, checked_q;
  logic             prime_q;
  logic             start_go, ack_take;

  always_comb begin
    state_d  = state_q;
    start_go = 1'b0;
    ack_take = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          start_go = 1'b1;
          // A limit below 2 has no candidates: finish without touching the engine.
          state_d  = (NumMax < NUM_W'(2)) ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        // Abort wins over a same-cycle ack; the result is dropped.
        if (Abort) state_d = ST_IDLE;
        else if (EngAck) begin
          ack_take = 1'b1;
          state_d  = (cand_q == max_q) ? ST_DONE : ST_NEXT;
        end
      end
      ST_NEXT: state_d = Abort ? ST_IDLE : ST_REQ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge SysClk) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      max_q     <= '0;
      cand_q    <= '0;
      checked_q <= '0;
      prime_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prime_q <= ack_take && EngPrime;
      if (start_go) begin
        max_q     <= NumMax;
        cand_q    <= NUM_W'(2);
        checked_q <= '0;
      end else begin
        if (ack_take) checked_q <= cand_q;
        if ((state_q == ST_NEXT) && !Abort) cand_q <= cand_q + NUM_W'(1);
      end
    end
  end

  assign EngReq        = (state_q == ST_REQ);
  assign EngNum        = cand_q;
  assign Busy          = (state_q == ST_REQ) || (state_q == ST_NEXT);
  assign Done          = (state_q == ST_DONE);
  assign Prime         = prime_q;
  assign NumberChecked = checked_q;

  // Abort freezes the tallies, so the abort cycle itself is not counted.
  sat_counter #(.WIDTH(CNT_W)) u_prime_cnt (
    .SysClk (SysClk),
    .Reset  (Reset),
    .clr    (start_go),
    .en     (ack_take && EngPrime),
    .count  (NumberofPrimesFound)
  );

  sat_counter #(.WIDTH(CYC_W)) u_cyc_cnt (
    .SysClk (SysClk),
    .Reset  (Reset),
    .clr    (start_go),
    .en     (Busy && !Abort),
    .count  (ClockCount)
  );
endmodule
